// File: rtl/if_stage_pfq_if.sv
// Fetch-stage bus bundle: instruction-memory request/response port plus the
// valid/ready hand-off towards decode. The fetch stage uses the master view.
interface if_stage_pfq_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            if_valid;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_inst, if_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_inst, if_pc,
        output imem_gnt, imem_rvalid, imem_rdata, id_ready
    );
endinterface

// File: rtl/if_stage_pfq.sv
// Instruction fetch stage with prefetch queue.
// PC select by priority exc > ex > id > sequential; stale fetches squashed by
// an epoch bit; request credit = QDEPTH - (queued + outstanding).
// Optional macro IF_PERF_CNT_EN adds saturating perf_fetched/perf_squashed.
module if_stage_pfq #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] HANDLER_ADDR = 'h0000_00FE,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int unsigned     PC_STEP      = 1,
    parameter int unsigned     QDEPTH       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_redirect,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            id_redirect,
    input  logic [XLEN-1:0] id_target,
    input  logic            halt,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_squashed,
`endif
    if_stage_pfq_if.master  bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(QDEPTH);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t          state, next_state;
    logic [XLEN-1:0] q_inst [QDEPTH];
    logic [XLEN-1:0] q_pc   [QDEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, outstanding;
    logic            epoch, tag_epoch;
    logic [XLEN-1:0] fetch_pc, tag_pc, redirect_pc;
    logic            redirect, credit_ok, req, accept;
    logic            rsp_live, enq, deq, drop, q_valid;

    assign redirect  = exc_redirect | ex_redirect | id_redirect;
    assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_C;
    assign accept    = req & bus.imem_gnt;
    // A response is only meaningful while a request is actually in flight;
    // anything arriving after a reset is ignored.
    assign rsp_live  = bus.imem_rvalid & (outstanding != '0);
    assign enq       = rsp_live & ~redirect & (tag_epoch == epoch);
    assign drop      = rsp_live & ~enq;
    assign q_valid   = (count != '0);
    assign deq       = q_valid & bus.id_ready & ~redirect;

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;
    assign bus.if_valid  = q_valid;
    assign bus.if_inst   = q_valid ? q_inst[rd_ptr] : '0;
    assign bus.if_pc     = q_valid ? q_pc[rd_ptr]   : '0;

    // Redirect target selection by fixed priority.
    always_comb begin
        redirect_pc = id_target;
        if (exc_redirect)     redirect_pc = HANDLER_ADDR;
        else if (ex_redirect) redirect_pc = ex_target;
    end

    // Next-state and request generation; a redirect always suppresses the request.
    always_comb begin
        next_state = state;
        req        = 1'b0;
        case (state)
            BOOT:   next_state = RUN;
            RUN: begin
                req = ~redirect & credit_ok;
                if (!redirect && halt) next_state = HALTED;
            end
            HALTED: if (redirect) next_state = RUN;
            default: next_state = BOOT;
        endcase
    end

    // Control state: FSM, fetch PC, epoch, credit counters and queue pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            epoch       <= 1'b0;
            tag_epoch   <= 1'b0;
            outstanding <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state       <= next_state;
            outstanding <= outstanding + CW'(accept) - CW'(rsp_live);
            if (accept) tag_epoch <= epoch;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                epoch    <= ~epoch;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                count <= count + CW'(enq) - CW'(deq);
                if (enq) wr_ptr <= wr_ptr + AW'(1);
                if (deq) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Datapath storage: PC tag of the accepted request and queue entries.
    always_ff @(posedge clk) begin
        if (accept) tag_pc <= fetch_pc;
        if (enq) begin
            q_inst[wr_ptr] <= bus.imem_rdata;
            q_pc[wr_ptr]   <= tag_pc;
        end
    end

    // The credit rule keeps the queue from ever being written while full.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(enq && !deq && count == CW'(QDEPTH)));

`ifdef IF_PERF_CNT_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    logic [31:0] squash_inc;
    assign squash_inc = (redirect ? 32'(count) : 32'd0) + 32'(drop);

    // Saturating counters of delivered and squashed fetches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched  <= '0;
            perf_squashed <= '0;
        end else begin
            perf_fetched  <= sat_add(perf_fetched, 32'(enq));
            perf_squashed <= sat_add(perf_squashed, squash_inc);
        end
    end
`endif
endmodule

// File: tb/tb_if_stage_pfq.sv
// Directed bench for if_stage_pfq: reset, streaming, back-pressure, redirect
// priority, halt/exception, held request and PC wrap. The memory model answers
// every accepted request one cycle later with rdata = 0x1000_0000 | addr.
module tb_if_stage_pfq;
    logic        clk = 1'b0;
    logic        rst;
    logic        exc_redirect, ex_redirect, id_redirect, halt;
    logic [31:0] ex_target, id_target;
    int          n_run  = 0;
    int          n_fail = 0;
    int          nreq;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_squashed;
`endif

    if_stage_pfq_if #(.XLEN(32)) bus ();

    if_stage_pfq dut (
        .clk          (clk),
        .rst          (rst),
        .exc_redirect (exc_redirect),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .id_redirect  (id_redirect),
        .id_target    (id_target),
        .halt         (halt),
`ifdef IF_PERF_CNT_EN
        .perf_fetched (perf_fetched),
        .perf_squashed(perf_squashed),
`endif
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the request, cross the edge, answer an accepted request.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = bus.imem_req & bus.imem_gnt;
        a   = bus.imem_addr;
        @(posedge clk);
        #1;
        bus.imem_rvalid = acc;
        bus.imem_rdata  = acc ? (a | 32'h1000_0000) : 32'h0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; exc_redirect = 0; ex_redirect = 0; id_redirect = 0; halt = 0;
        ex_target = '0; id_target = '0;
        bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b1;
        tick(); tick();
        chk("rst_req",   bus.imem_req, 0);
        chk("rst_valid", bus.if_valid, 0);
        chk("rst_inst",  bus.if_inst,  0);
        chk("rst_pc",    bus.if_pc,    0);

        // Streaming from reset: BOOT cycle, then requests 0,1,2..., data from cycle 3.
        rst = 1'b1;
        chk("boot_req", bus.imem_req, 0);
        tick();
        chk("c1_req",  bus.imem_req,  1);
        chk("c1_addr", bus.imem_addr, 32'h0);
        tick();
        chk("c2_addr",  bus.imem_addr, 32'h1);
        chk("c2_valid", bus.if_valid,  0);
        tick();
        chk("c3_valid", bus.if_valid, 1);
        chk("c3_pc",    bus.if_pc,    32'h0);
        chk("c3_inst",  bus.if_inst,  32'h1000_0000);
        tick();
        chk("c4_pc", bus.if_pc, 32'h1);
        tick();
        chk("c5_pc", bus.if_pc, 32'h2);

        // Asynchronous reset mid-stream while a response is on the bus.
        bus.id_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_req",   bus.imem_req, 0);
        chk("mid_rst_valid", bus.if_valid, 0);
        chk("mid_rst_inst",  bus.if_inst,  0);
        chk("mid_rst_pc",    bus.if_pc,    0);
        rst = 1'b1;

        // Back-pressure: only QDEPTH fetches may be in flight or queued.
        nreq = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.imem_req) nreq++;
        end
        chk("bp_reqs",  nreq, 4);
        chk("bp_req",   bus.imem_req, 0);
        chk("bp_valid", bus.if_valid, 1);
        bus.id_ready = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) tick();
            chk("bp_order", bus.if_pc, k);
        end

        // Redirect with 3 queued entries and a response in the redirect cycle.
        bus.id_ready = 1'b0;
        tick();
        chk("pre_redir_pc", bus.if_pc, 32'h5);
        ex_redirect = 1; ex_target = 32'h40; id_redirect = 1; id_target = 32'h80;
        #1;
        chk("redir_req", bus.imem_req, 0);
        tick();
        ex_redirect = 0; id_redirect = 0; bus.id_ready = 1'b1;
        #1;
        chk("redir_t1_valid", bus.if_valid,  0);
        chk("redir_t1_addr",  bus.imem_addr, 32'h40);
        tick();
        chk("redir_t2_valid", bus.if_valid, 0);
        tick();
        chk("redir_t3_valid", bus.if_valid, 1);
        chk("redir_t3_pc",    bus.if_pc,    32'h40);
        chk("redir_t3_inst",  bus.if_inst,  32'h1000_0040);
        tick();
        chk("redir_t4_pc", bus.if_pc, 32'h41);

        // Halt; dropping halt does not resume; exception restarts at the handler.
        halt = 1;
        tick(); tick();
        halt = 0;
        #1;
        chk("halted_req0", bus.imem_req, 0);
        tick();
        chk("halted_req1", bus.imem_req, 0);
        exc_redirect = 1;
        #1;
        chk("exc_req", bus.imem_req, 0);
        tick();
        exc_redirect = 0;
        #1;
        chk("exc_t1_req",  bus.imem_req,  1);
        chk("exc_t1_addr", bus.imem_addr, 32'hFE);
        tick();
        chk("exc_t2_addr", bus.imem_addr, 32'hFF);
        tick();
        chk("exc_t3_valid", bus.if_valid, 1);
        chk("exc_t3_pc",    bus.if_pc,    32'hFE);

        // Grant withheld for 3 cycles: address must hold.
        bus.imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_req",  bus.imem_req,  1);
            chk("hold_addr", bus.imem_addr, 32'h100);
            tick();
        end
        bus.imem_gnt = 1'b1;
        chk("hold_gnt_addr", bus.imem_addr, 32'h100);
        tick();
        chk("post_gnt_addr", bus.imem_addr, 32'h101);

        // Sequential PC wraps past all-ones.
        ex_redirect = 1; ex_target = 32'hFFFF_FFFF;
        #1;
        chk("wrap_req", bus.imem_req, 0);
        tick();
        ex_redirect = 0;
        #1;
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFF);
        tick();
        chk("wrap_addr1", bus.imem_addr, 32'h0);
        tick();
        chk("wrap_pc0", bus.if_pc, 32'hFFFF_FFFF);
        tick();
        chk("wrap_pc1",   bus.if_pc,   32'h0);
        chk("wrap_inst1", bus.if_inst, 32'h1000_0000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage_pfq.md
Name: if_stage_pfq

Overview:
Parametrised successor of the single-cycle fetch stage. Decouples PC generation from decode through an instruction prefetch queue and a valid/ready fetch port to instruction memory. Selects the next PC from exception, EX-branch, ID-branch and sequential sources by fixed priority. Squashes stale in-flight fetches with an epoch bit. Sits between instruction memory and the IF/ID pipeline register.

Parameters:
XLEN, 32, instruction and PC width
HANDLER_ADDR, 32'h0000_00FE, exception handler target
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 1, sequential PC increment (word-addressed memory)
QDEPTH, 4, prefetch queue entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
exc_redirect  in  1  redirect to HANDLER_ADDR
ex_redirect  in  1  EX-stage branch/jump redirect
ex_target  in  XLEN  EX redirect target
id_redirect  in  1  ID-stage jump redirect
id_target  in  XLEN  ID redirect target
halt  in  1  stop issuing fetches
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address
imem_gnt  in  1  memory accepts request
imem_rvalid  in  1  read data valid, exactly 1 cycle after accept, in order
imem_rdata  in  XLEN  instruction word
if_valid  out  1  instruction available to decode
if_inst  out  XLEN  instruction
if_pc  out  XLEN  PC of if_inst
id_ready  in  1  decode consumes (stall = !id_ready)

Behaviour:
- rst=0 (async): fetch_pc=RESET_PC, queue empty, outstanding=0, epoch=0, state=BOOT; imem_req=0, if_valid=0, if_inst=0, if_pc=0.
- FSM: BOOT -> RUN on first clock after rst release (no request in BOOT). RUN -> HALTED when halt=1 and no redirect. HALTED -> RUN on any redirect. halt=0 in HALTED does not resume.
- Redirect priority: exc > ex > id. Any redirect in cycle t: fetch_pc<=target, queue flushed, epoch toggled, imem_req forced 0 in cycle t.
- imem_req=1 in RUN when no redirect and queue_count+outstanding < QDEPTH. imem_addr=fetch_pc. On imem_req&imem_gnt: fetch_pc += PC_STEP (modulo 2^XLEN wrap), outstanding++, request tagged with current epoch and PC.
- Held request: imem_addr stable while imem_req=1 and imem_gnt=0, unless a redirect occurs.
- Response: imem_rvalid decrements outstanding. If its tag epoch equals current epoch, {rdata,pc} enqueues at that edge; otherwise it is dropped. A response arriving in the redirect cycle is dropped.
- Output: if_valid = queue non-empty (registered); if_inst/if_pc = head entry. Dequeue on if_valid & id_ready & no redirect.
- Enqueue and dequeue in the same cycle are legal at any count. Overflow is impossible by the credit rule; write-on-full is an assertion failure.
- Latency: redirect at t -> request t+1 -> rvalid t+2 -> if_valid t+3 (gnt immediate). Steady state: 1 instruction/cycle.
- rst asserted mid-operation: immediate return to the reset state; responses already in flight are dropped.

Optional Feature:
IF_PERF_CNT_EN: adds outputs perf_fetched (32b, epoch-matching responses enqueued) and perf_squashed (32b, dropped responses plus entries flushed by redirect). Both saturate at all-ones and reset to 0. Without the macro, the ports and logic are absent.

Test Plan:
- Reset release, gnt=1, id_ready=1 -> requests at addr 0,1,2,... from cycle 1; if_valid from cycle 3 with if_pc=0,1,2 consecutively.
- id_ready=0 for 10 cycles -> exactly QDEPTH=4 requests outstanding/queued, imem_req=0 afterwards. id_ready=1 -> PCs 0..3 delivered in order, no loss or duplicate.
- ex_redirect target 0x40 with id_redirect 0x80 in the same cycle, queue holding 3 entries -> if_valid=0 next cycle, first new if_pc=0x40 at t+3, old response dropped.
- exc_redirect during a halted state -> if_pc=0x000000FE delivered; state RUN.
- imem_gnt=0 for 3 cycles -> imem_addr held constant; fetch_pc advances only on gnt.
- fetch_pc = 0xFFFFFFFF -> next request address 0x00000000. rst pulsed low mid-stream -> all outputs 0 asynchronously; fetch restarts at RESET_PC.
